// File: rtl/pixel_writer_pkg.sv
// Shared types and constants for the pixel write path: pixel record, writer
// state encoding and the half-word lane select helper.
package pixel_writer_pkg;

    localparam int PIXEL_BYTES_LOG2 = 1;

    localparam int DEF_ROW_BITS   = 8;
    localparam int DEF_COL_BITS   = 8;
    localparam int DEF_PIXEL_BITS = 16;

    typedef struct packed {
        logic [DEF_ROW_BITS-1:0]   row;
        logic [DEF_COL_BITS-1:0]   col;
        logic [DEF_PIXEL_BITS-1:0] color;
    } pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pw_state_e;

    // A 16-bit pixel occupies the upper or lower half of the 32-bit bus word.
    function automatic logic [3:0] lane_enable(input logic upper_half);
        if (upper_half) begin
            return 4'b1100;
        end else begin
            return 4'b0011;
        end
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Combinational pixel address unit: base/row/col to word address, byte lanes
// and in-frame flag. Shared by the writer and any future pixel reader.
module pixel_addr_gen
    import pixel_writer_pkg::*;
#(
    parameter int TOTAL_ROWS      = 192,
    parameter int TOTAL_COLS      = 256,
    parameter int ROW_STRIDE_LOG2 = 9,
    parameter int RW              = 8,
    parameter int CW              = 8
) (
    input  logic [31:0]   base,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    output logic [31:0]   address,
    output logic [3:0]    byteenable,
    output logic          inrange
);

    logic [31:0] row_off_s;
    logic [31:0] col_off_s;
    logic [31:0] sum_s;
    logic        unused_lsb_s;

    // Byte address sum wraps modulo 2^32; the bus sees the word address and
    // selects the half-word through byteenable.
    always_comb begin
        row_off_s    = 32'($unsigned(row)) << ROW_STRIDE_LOG2;
        col_off_s    = 32'($unsigned(col)) << PIXEL_BYTES_LOG2;
        sum_s        = base + row_off_s + col_off_s;
        address      = {sum_s[31:2], 2'b00};
        byteenable   = lane_enable(sum_s[1]);
        inrange      = (32'($unsigned(row)) < 32'($unsigned(TOTAL_ROWS))) &&
                       (32'($unsigned(col)) < 32'($unsigned(TOTAL_COLS)));
        unused_lsb_s = sum_s[0];
    end

endmodule

// File: rtl/pixel_writer.sv
// Render pipeline back end: takes shaded pixels over valid/ready, writes them
// to the frame buffer through Avalon-MM master m1, and signals frame completion.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter  int TOTAL_ROWS      = 192,
    parameter  int TOTAL_COLS      = 256,
    parameter  int PIXEL_BITS      = 16,
    parameter  int ROW_STRIDE_LOG2 = 9,
    localparam int RW              = $clog2(TOTAL_ROWS),
    localparam int CW              = $clog2(TOTAL_COLS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           pixel_buffer,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [RW-1:0]         pix_row,
    input  logic [CW-1:0]         pix_col,
    input  logic [PIXEL_BITS-1:0] pix_color,
    output logic [31:0]           m1_address,
    output logic [31:0]           m1_writedata,
    output logic [3:0]            m1_byteenable,
    output logic                  m1_write,
    input  logic                  m1_waitrequest,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           pixel_count
);

    localparam logic [31:0] FRAME_PIXELS = 32'(TOTAL_ROWS * TOTAL_COLS);

    pw_state_e   state_r;
    pw_state_e   state_next_s;

    logic [31:0] base_r;
    logic [31:0] count_r;
    logic        last_pending_r;
    logic        done_r;

    logic        full_r;
    logic        inrange_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [3:0]  be_r;

    logic [31:0] gen_addr_s;
    logic [3:0]  gen_be_s;
    logic        gen_inrange_s;

    logic        arm_s;
    logic        retire_s;
    logic        final_retire_s;
    logic        ready_s;
    logic        accept_s;
    logic        completes_s;

    pixel_addr_gen #(
        .TOTAL_ROWS      (TOTAL_ROWS),
        .TOTAL_COLS      (TOTAL_COLS),
        .ROW_STRIDE_LOG2 (ROW_STRIDE_LOG2),
        .RW              (RW),
        .CW              (CW)
    ) u_addr_gen (
        .base       (base_r),
        .row        (pix_row),
        .col        (pix_col),
        .address    (gen_addr_s),
        .byteenable (gen_be_s),
        .inrange    (gen_inrange_s)
    );

    // Handshake and retire qualifiers; ready looks through a retiring entry so
    // capture and retire can share an edge.
    always_comb begin
        arm_s          = (state_r == IDLE) && start;
        retire_s       = full_r && (!inrange_r || !m1_waitrequest);
        final_retire_s = retire_s && ((count_r + 32'd1) == FRAME_PIXELS);
        ready_s        = (state_r == RUN) && (!full_r || retire_s) && !last_pending_r;
        accept_s       = pix_valid && ready_s;
        completes_s    = (count_r + 32'($unsigned(full_r)) + 32'd1) == FRAME_PIXELS;
    end

    // Frame state next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (final_retire_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame base, retire counter, last-pixel guard and completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_r         <= 32'd0;
            count_r        <= 32'd0;
            last_pending_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= final_retire_s;
            if (arm_s) begin
                base_r         <= pixel_buffer;
                count_r        <= 32'd0;
                last_pending_r <= 1'b0;
            end else begin
                if (retire_s) begin
                    count_r <= count_r + 32'd1;
                end
                if (final_retire_s) begin
                    last_pending_r <= 1'b0;
                end else if (accept_s && completes_s) begin
                    last_pending_r <= 1'b1;
                end
            end
        end
    end

    // One-entry holding register; bus fields stay frozen while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_r    <= 1'b0;
            inrange_r <= 1'b0;
            addr_r    <= 32'd0;
            data_r    <= 32'd0;
            be_r      <= 4'b0000;
        end else if (accept_s) begin
            full_r    <= 1'b1;
            inrange_r <= gen_inrange_s;
            addr_r    <= gen_addr_s;
            data_r    <= {pix_color, pix_color};
            be_r      <= gen_be_s;
        end else if (retire_s) begin
            full_r    <= 1'b0;
        end
    end

    assign pix_ready     = ready_s;
    assign m1_address    = addr_r;
    assign m1_writedata  = data_r;
    assign m1_byteenable = be_r;
    assign m1_write      = full_r && inrange_r;
    assign busy          = (state_r == RUN);
    assign frame_done    = done_r;
    assign pixel_count   = count_r;

endmodule
